// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    ERR
  } lsu_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return op <= 4'd6;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'd8) && (op <= 4'd10);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] b);
    case (lsu_op_t'(op))
      LH, LHU, SH: return b[0];
      LW, SW:      return b != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_load_fmt.sv
// Combinational load formatter: picks bytes out of a big-endian word, extends, or merges with rt.
module mips_lsu_load_fmt
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  b_i,
  input  logic [31:0] w_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] result_o
);

  logic [4:0]  lsh;
  logic [4:0]  rsh;
  logic [31:0] w_shr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] keep_l;
  logic [31:0] keep_r;

  always_comb begin
    // Byte offset b sits 8*(3-b) bits up from the bottom of the word.
    lsh    = {b_i, 3'b000};
    rsh    = {~b_i, 3'b000};
    w_shr  = w_i >> rsh;
    byte_v = w_shr[7:0];
    half_v = b_i[1] ? w_i[15:0] : w_i[31:16];
    keep_l = ~(32'hFFFF_FFFF << lsh);
    keep_r = ~(32'hFFFF_FFFF >> rsh);
    result_o = 32'd0;
    case (lsu_op_t'(op_i))
      LB:      result_o = {{24{byte_v[7]}}, byte_v};
      LBU:     result_o = {24'd0, byte_v};
      LH:      result_o = {{16{half_v[15]}}, half_v};
      LHU:     result_o = {16'd0, half_v};
      LW:      result_o = w_i;
      LWL:     result_o = (w_i << lsh) | (rt_old_i & keep_l);
      LWR:     result_o = w_shr | (rt_old_i & keep_r);
      default: result_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store initiator: one request -> one word-aligned bus access; response 3 edges after accept
// for loads, 2 for stores, 1 for errors. Single outstanding request; req_ready only in IDLE.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_store_data,
  input  logic [DATA_W-1:0] req_rt_old,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  lsu_state_t        state_q;
  logic [3:0]        op_q;
  logic [1:0]        b_q;
  logic [DATA_W-1:0] rt_old_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [3:0]        mem_be_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic [3:0]        st_be_d;
  logic [DATA_W-1:0] st_wd_d;
  logic [DATA_W-1:0] load_result;
  logic              req_bad;

  assign req_ready = (state_q == IDLE) && !reset;
  assign req_bad   = misaligned(req_op, req_addr[1:0]) || !(is_load(req_op) || is_store(req_op));

  // Store lanes: bus lane k carries byte offset 3-k.
  always_comb begin
    st_be_d = 4'b0000;
    st_wd_d = '0;
    case (lsu_op_t'(req_op))
      SB: begin
        st_wd_d = {4{req_store_data[7:0]}};
        st_be_d = 4'b0001 << (~req_addr[1:0]);
      end
      SH: begin
        st_wd_d = {2{req_store_data[15:0]}};
        st_be_d = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      SW: begin
        st_wd_d = req_store_data;
        st_be_d = 4'b1111;
      end
      default: ;
    endcase
  end

  mips_lsu_load_fmt u_load_fmt (
    .op_i     (op_q),
    .b_i      (b_q),
    .w_i      (mem_readdata),
    .rt_old_i (rt_old_q),
    .result_o (load_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= 4'd0;
      b_q           <= 2'd0;
      rt_old_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_be_q      <= 4'b0000;
      mem_wd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
          if (req_valid) begin
            op_q     <= req_op;
            b_q      <= req_addr[1:0];
            rt_old_q <= req_rt_old;
            if (req_bad) begin
              state_q      <= ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (is_load(req_op)) begin
              state_q       <= RD_ISSUE;
              mem_read_q    <= 1'b1;
              mem_address_q <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be_q      <= 4'b1111;
            end else begin
              state_q       <= WR_ISSUE;
              mem_write_q   <= 1'b1;
              mem_address_q <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be_q      <= st_be_d;
              mem_wd_q      <= st_wd_d;
            end
          end
        end
        RD_ISSUE: begin
          state_q       <= RD_WAIT;
          mem_read_q    <= 1'b0;
          mem_address_q <= '0;
          mem_be_q      <= 4'b0000;
        end
        RD_WAIT: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
          resp_data_q  <= load_result;
        end
        WR_ISSUE: begin
          state_q       <= IDLE;
          mem_write_q   <= 1'b0;
          mem_address_q <= '0;
          mem_be_q      <= 4'b0000;
          mem_wd_q      <= '0;
          resp_valid_q  <= 1'b1;
          resp_data_q   <= '0;
        end
        ERR: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_data      = resp_data_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byteenable = mem_be_q;
  assign mem_writedata  = mem_wd_q;

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Load/store initiator between the MIPS datapath and the byte-addressed `mips_memory` responder.
- Converts one load/store request into one word-aligned bus access, using `mem_read`/`mem_write`, `mem_byteenable` and `mem_writedata`.
- Waits out the responder's one-cycle registered read latency, then returns the formatted load result (sign/zero extension, LWL/LWR merge) or a store-done pulse.
- Addresses pass through unmodified; region mapping (0xBFC00000 boot space) belongs to the memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus/register width; only 32 is supported.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high when the LSU can accept a request.
- req_op  in  4  lsu_op_t operation.
- req_addr  in  32  byte address.
- req_store_data  in  32  rt value for stores.
- req_rt_old  in  32  current rt value for the LWL/LWR merge.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved op; valid with resp_valid.
- mem_address  out  32  word-aligned address.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byteenable  out  4  lane enables.
- mem_writedata  out  32  store data.
- mem_readdata  in  32  data returned one cycle after the read edge.

Behaviour:
- Reset: every output is 0 (including req_ready) while reset is high; the state is IDLE. In the cycle after reset deasserts, req_ready=1.
- Bus byte order is big-endian. Lane k (mem_byteenable[k], bits [8k+7:8k]) holds byte offset 3-k of the word. mem_address = {req_addr[31:2],2'b00}.
- req_ready = (state==IDLE). A request is accepted at a rising edge where req_valid && req_ready; op, addr, store_data and rt_old are captured into registers at that edge.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, ERR.
  - IDLE -> ERR: misaligned request or reserved op.
  - IDLE -> RD_ISSUE: load.
  - IDLE -> WR_ISSUE: store.
- Misalignment rules:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - LB/LBU/SB/LWL/LWR never misalign.
- ERR: no bus activity at any time. resp_valid=1, resp_err=1, resp_data=0 for one cycle, then IDLE.
- Load timing (accept edge = n):
  - RD_ISSUE: mem_read=1, byteenable=4'b1111 for the cycle after n; the memory samples at edge n+1.
  - RD_WAIT: mem_read=0. At edge n+2 the formatted mem_readdata is registered into resp_data.
  - resp_valid is high for exactly one cycle after edge n+2; state is IDLE in that same cycle. Load-to-response latency is 3 edges.
- Load formatting (b = addr[1:0]; w = word read):
  - LB: sign-extended byte at offset b, w[31-8b -: 8]. LBU: the same, zero-extended.
  - LH: sign-extended halfword at b (0 or 2). LHU: the same, zero-extended.
  - LW: w.
  - LWL: bytes b..3 of w go into the top of rt_old; the low b bytes of rt_old are kept.
  - LWR: bytes 0..b of w go into the bottom of rt_old; the top 3-b bytes are kept.
- Store timing:
  - WR_ISSUE: mem_write=1 for the cycle after n; the memory writes at edge n+1.
  - resp_valid=1 and resp_data=0 for the cycle after edge n+1.
- Store lane mapping:
  - SB: writedata={4{sd[7:0]}}, byteenable=1<<(3-b).
  - SH: writedata={2{sd[15:0]}}, byteenable=4'b1100 (b=0) or 4'b0011 (b=2).
  - SW: writedata=sd, byteenable=4'b1111.
- mem_read and mem_write are never high together. All mem_* and resp_* outputs are registered; mem_address, mem_byteenable and mem_writedata are 0 outside issue states.
- A request presented while req_ready=0 is ignored; it is not queued.
- Reset asserted in any state:
  - next state is IDLE;
  - strobes drop at the next edge;
  - the pending response is discarded (no resp_valid);
  - any write already sampled by the memory stands.

Decomposition:
- Package mips_lsu_pkg holds:
  - lsu_op_t with encodings LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10; all other encodings are reserved;
  - the lsu_state_t enum;
  - the is_load/is_store/misaligned helper functions.
- One sub-module, mips_lsu_load_fmt: combinational extract/extend/merge of (op, b, w, rt_old) -> result.

Test Plan:
- Memory word at 0x10 = 0x8899AABB.
  - LB @0x11 -> resp_data 0xFFFFFF99.
  - LBU @0x11 -> 0x00000099.
  - mem_address=0x10 and mem_read are seen exactly one cycle per load.
- LH @0x12 -> 0xFFFFAABB; LHU @0x10 -> 0x00008899; resp_valid exactly 3 edges after accept.
- SB @0x13 sd=0x000000CC -> mem_byteenable 4'b0001, mem_writedata 0xCCCCCCCC, mem_address 0x10; then LW @0x10 -> 0x8899AACC.
- rt_old=0x11223344:
  - LWL @0x11 -> 0x99AABB44.
  - LWR @0x11 -> 0x11228899.
  - LWL @0x10 and LWR @0x13 -> 0x8899AABB.
- LW @0x12 and SH @0x11 -> resp_err=1, resp_data=0 one edge after accept; mem_read/mem_write never asserted. Reserved op 4'hF gives the same response.
- Reset asserted in RD_WAIT -> no resp_valid, outputs 0. req_valid held high across two LWs -> the second is accepted only once req_ready=1, and responses are in order.
